// File: rtl/arbiter_stream_mux_pkg.sv
// Shared definitions for the stream arbiter/mux: FSM encoding and select width.
package arbiter_stream_mux_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    LOCK = 1'b1
  } state_t;

  // Beat counter width; holds up to 255 beats per grant.
  localparam int CNT_W = 8;

  // Width of a port index; at least one bit even for tiny port counts.
  function automatic int sel_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/arbiter_stream_mux_rr_pick.sv
// Combinational round-robin picker: first requester at or after ptr, wrapping.
module rr_pick
  import arbiter_stream_mux_pkg::*;
#(
  parameter  int NUM_PORTS = 4,
  localparam int SW        = sel_width(NUM_PORTS)
) (
  input  logic [NUM_PORTS-1:0] req,
  input  logic [SW-1:0]        ptr,
  output logic [NUM_PORTS-1:0] grant,
  output logic [SW-1:0]        idx,
  output logic                 any
);

  logic [SW:0]   c_w;
  logic [SW-1:0] c;

  // Scan ports in priority order starting at ptr; keep the first hit.
  always_comb begin
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    c_w   = '0;
    c     = '0;
    for (int off = 0; off < NUM_PORTS; off++) begin
      c_w = {1'b0, ptr} + (SW+1)'(off);
      if (c_w >= (SW+1)'(NUM_PORTS)) c_w = c_w - (SW+1)'(NUM_PORTS);
      c = c_w[SW-1:0];
      if (!any && req[c]) begin
        any      = 1'b1;
        grant[c] = 1'b1;
        idx      = c;
      end
    end
  end

endmodule

// File: rtl/arbiter_stream_mux.sv
// Packet-granular round-robin stream mux with a per-grant burst cap.
// One IDLE arbitration cycle precedes every grant; LOCK passes beats through
// combinationally from the granted port.
module arbiter_stream_mux
  import arbiter_stream_mux_pkg::*;
#(
  parameter  int NUM_PORTS  = 4,
  parameter  int DATA_WIDTH = 32,
  parameter  int MAX_BURST  = 16,
  localparam int SEL_WIDTH  = sel_width(NUM_PORTS)
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0] s_data,
  input  logic [NUM_PORTS-1:0]            s_valid,
  input  logic [NUM_PORTS-1:0]            s_last,
  output logic [NUM_PORTS-1:0]            s_ready,
  output logic [DATA_WIDTH-1:0]           m_data,
  output logic                            m_valid,
  output logic                            m_last,
  input  logic                            m_ready,
  output logic [SEL_WIDTH-1:0]            m_select,
  output logic                            active
);

  logic [NUM_PORTS-1:0][DATA_WIDTH-1:0] data_arr;
  state_t                               state;
  logic [CNT_W-1:0]                     beat_cnt;
  logic [SEL_WIDTH-1:0]                 ptr;
  logic [NUM_PORTS-1:0]                 grant_oh;
  logic [NUM_PORTS-1:0]                 pick_grant;
  logic [SEL_WIDTH-1:0]                 pick_idx;
  logic                                 pick_any;
  logic                                 lock_out;
  logic                                 xfer;
  logic                                 burst_end;
  logic [SEL_WIDTH-1:0]                 nxt_ptr;

  assign data_arr = s_data;

  rr_pick #(.NUM_PORTS(NUM_PORTS)) u_pick (
    .req   (s_valid),
    .ptr   (ptr),
    .grant (pick_grant),
    .idx   (pick_idx),
    .any   (pick_any)
  );

  // Pass-through is gated by reset so nothing is accepted in a reset cycle.
  assign lock_out  = (state == LOCK) && rst;
  assign xfer      = m_valid && m_ready;
  assign burst_end = (beat_cnt == CNT_W'(MAX_BURST - 1));
  assign nxt_ptr   = (m_select == SEL_WIDTH'(NUM_PORTS - 1)) ? '0 : m_select + 1'b1;
  assign active    = (state == LOCK);

  // Combinational mux from the granted port to the output stream.
  always_comb begin
    m_data  = data_arr[m_select];
    m_valid = lock_out && s_valid[m_select];
    m_last  = lock_out && s_last[m_select];
    s_ready = lock_out ? (grant_oh & {NUM_PORTS{m_ready}}) : '0;
  end

  // Grant FSM, beat counter and round-robin pointer.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= IDLE;
      beat_cnt <= '0;
      m_select <= '0;
      grant_oh <= '0;
      ptr      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pick_any) begin
            state    <= LOCK;
            m_select <= pick_idx;
            grant_oh <= pick_grant;
            beat_cnt <= '0;
          end
        end
        LOCK: begin
          if (xfer) begin
            if (m_last || burst_end) begin
              // Release: just-served port drops to lowest priority.
              state    <= IDLE;
              ptr      <= nxt_ptr;
              beat_cnt <= '0;
            end else begin
              beat_cnt <= beat_cnt + 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_arbiter_stream_mux.sv
// Randomized + directed bench for arbiter_stream_mux against a behavioural model.
module tb_arbiter_stream_mux;
  localparam int NP = 4;
  localparam int DW = 32;
  localparam int MB = 16;

  logic              clk = 1'b0;
  logic              rst;
  logic [NP*DW-1:0]  s_data;
  logic [NP-1:0]     s_valid, s_last, s_ready;
  logic [DW-1:0]     m_data;
  logic              m_valid, m_last, m_ready;
  logic [1:0]        m_select;
  logic              active;

  always #5 clk = ~clk;

  arbiter_stream_mux #(.NUM_PORTS(NP), .DATA_WIDTH(DW), .MAX_BURST(MB)) dut (
    .clk(clk), .rst(rst), .s_data(s_data), .s_valid(s_valid), .s_last(s_last),
    .s_ready(s_ready), .m_data(m_data), .m_valid(m_valid), .m_last(m_last),
    .m_ready(m_ready), .m_select(m_select), .active(active)
  );

  typedef struct { logic [DW-1:0] d; logic l; } beat_t;

  beat_t srcq [NP][$];   // beats still to be offered by each source
  beat_t sbq  [NP][$];   // beats expected to leave, per port, in order
  int    seqn [NP];
  int    total = 0, bad = 0;

  // model state: owner port (-1 = no grant), beats in grant, pointer, last select
  int own = -1, mbeats = 0, mptr = 0, msel = 0;
  int glog[$];

  // stimulus controls, applied at the next negedge
  logic          rst_nx, mrdy_nx;
  bit            force_v;
  logic [NP-1:0] vmask;
  int            vprob;

  task automatic chk(input string nm, input logic [63:0] a, input logic [63:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", nm, a, e);
    end
  endtask

  task automatic add_pkt(input int p, input int len);
    beat_t b;
    for (int i = 0; i < len; i++) begin
      b.d = DW'((p << 24) | (seqn[p] & 'hFFFFFF));
      b.l = (i == len - 1);
      seqn[p]++;
      srcq[p].push_back(b);
      sbq[p].push_back(b);
    end
  endtask

  task automatic cycle();
    beat_t         b;
    logic [NP-1:0] er;
    logic          emv, eml;
    logic [DW-1:0] emd;
    bit            found;
    int            c;
    @(negedge clk);
    rst     = rst_nx;
    m_ready = mrdy_nx;
    for (int p = 0; p < NP; p++) begin
      if (force_v) begin
        s_valid[p] = 1'b1; s_data[p*DW +: DW] = '0; s_last[p] = 1'b0;
      end else if (srcq[p].size() > 0 && !vmask[p] && $urandom_range(99) < vprob) begin
        b = srcq[p][0];
        s_valid[p] = 1'b1; s_data[p*DW +: DW] = b.d; s_last[p] = b.l;
      end else begin
        s_valid[p] = 1'b0; s_data[p*DW +: DW] = $urandom; s_last[p] = 1'($urandom_range(1));
      end
    end
    #1;
    // expected outputs from the model
    er = '0; emv = 1'b0; eml = 1'b0; emd = '0;
    if (rst && own >= 0) begin
      emv = s_valid[own]; eml = s_last[own]; emd = s_data[own*DW +: DW]; er[own] = m_ready;
    end
    chk("s_ready", 64'(s_ready), 64'(er));
    chk("m_valid", 64'(m_valid), 64'(emv));
    chk("m_last", 64'(m_last), 64'(eml));
    chk("active", 64'(active), 64'(own >= 0));
    chk("m_select", 64'(m_select), 64'(msel));
    if (emv) chk("m_data", 64'(m_data), 64'(emd));
    // scoreboard: every beat the DUT accepts must be the next one of that port
    for (int p = 0; p < NP; p++) begin
      if (rst && s_valid[p] && s_ready[p] === 1'b1) begin
        if (sbq[p].size() == 0) begin
          chk("sb_extra_beat", 64'(p), 64'hFFFF);
        end else begin
          b = sbq[p].pop_front();
          chk("sb_data", 64'(m_data), 64'(b.d));
          chk("sb_last", 64'(m_last), 64'(b.l));
        end
      end
    end
    // advance model across the coming edge
    if (!rst) begin
      own = -1; mbeats = 0; msel = 0; mptr = 0;
    end else if (own < 0) begin
      found = 0;
      for (int k = 0; k < NP; k++) begin
        c = (mptr + k) % NP;
        if (!found && s_valid[c]) begin
          found = 1; own = c; msel = c; mbeats = 0; glog.push_back(c);
        end
      end
    end else if (s_valid[own] && m_ready) begin
      if (srcq[own].size() > 0) b = srcq[own].pop_front();
      mbeats++;
      if (s_last[own] || mbeats == MB) begin
        mptr = (own + 1) % NP;
        own  = -1;
      end
    end
  endtask

  task automatic wait_beats(input int p, input int k);
    int n = 0;
    while (!(own == p && mbeats == k) && n < 300) begin cycle(); n++; end
    if (n >= 300) chk("wait_beats_timeout", 64'(n), 64'd0);
  endtask

  task automatic drain(output int n);
    bit busy;
    n = 0;
    do begin
      busy = (own >= 0);
      for (int p = 0; p < NP; p++) if (srcq[p].size() > 0) busy = 1;
      if (busy) begin cycle(); n++; end
    end while (busy && n < 6000);
    if (busy) chk("drain_timeout", 64'(n), 64'd0);
  endtask

  initial begin
    int n;
    int exp2[5] = '{0, 1, 2, 3, 0};
    rst = 1'b0; m_ready = 1'b1; s_valid = '0; s_last = '0; s_data = '0;
    rst_nx = 1'b0; mrdy_nx = 1'b1; force_v = 1; vmask = '0; vprob = 100;
    @(posedge clk);

    // reset held with every port requesting
    repeat (10) begin
      cycle();
      chk("rst_s_ready", 64'(s_ready), 64'd0);
      chk("rst_m_valid", 64'(m_valid), 64'd0);
      chk("rst_active", 64'(active), 64'd0);
      chk("rst_m_select", 64'(m_select), 64'd0);
    end
    force_v = 0; rst_nx = 1'b1;
    repeat (2) cycle();

    // four ports of 3-beat packets, plus a second one on port 0
    glog.delete();
    for (int p = 0; p < NP; p++) add_pkt(p, 3);
    add_pkt(0, 3);
    drain(n);
    chk("rr_grants", 64'(glog.size()), 64'd5);
    for (int i = 0; i < 5 && i < glog.size(); i++) chk("rr_order", 64'(glog[i]), 64'(exp2[i]));
    chk("rr_cycles", 64'(n), 64'd20);

    // 40-beat packet capped at 16 beats per grant
    glog.delete();
    add_pkt(2, 40);
    drain(n);
    chk("burst_grants", 64'(glog.size()), 64'd3);
    chk("burst_cycles", 64'(n), 64'd43);

    // downstream stall mid-packet
    add_pkt(1, 6);
    wait_beats(1, 2);
    mrdy_nx = 1'b0;
    repeat (5) begin
      cycle();
      chk("stall_m_valid", 64'(m_valid), 64'd1);
      chk("stall_s_ready1", 64'(s_ready[1]), 64'd0);
      chk("stall_m_data", 64'(m_data), 64'((1 << 24) | (seqn[1] - 4)));
    end
    mrdy_nx = 1'b1;
    drain(n);

    // granted port goes quiet while another port requests
    glog.delete();
    add_pkt(3, 6);
    wait_beats(3, 2);
    vmask[3] = 1'b1;
    add_pkt(0, 2);
    repeat (4) begin
      cycle();
      chk("hold_m_select", 64'(m_select), 64'd3);
      chk("hold_active", 64'(active), 64'd1);
    end
    vmask = '0;
    drain(n);
    chk("hold_grants", 64'(glog.size()), 64'd2);
    if (glog.size() == 2) chk("hold_second", 64'(glog[1]), 64'd0);

    // one-cycle reset mid-packet, then ports 0 and 1 both request
    add_pkt(1, 6);
    wait_beats(1, 2);
    add_pkt(0, 3);
    rst_nx = 1'b0;
    cycle();
    rst_nx = 1'b1;
    glog.delete();
    cycle();
    chk("rstmid_active", 64'(active), 64'd0);
    chk("rstmid_s_ready", 64'(s_ready), 64'd0);
    drain(n);
    chk("rstmid_first", 64'(glog.size() > 0 ? glog[0] : -1), 64'd0);

    // random traffic with gaps and back-pressure
    vprob = 70;
    for (int i = 0; i < 3000; i++) begin
      int p;
      if ($urandom_range(9) == 0) begin
        p = $urandom_range(NP - 1);
        if (srcq[p].size() < 20) add_pkt(p, $urandom_range(40, 1));
      end
      mrdy_nx = ($urandom_range(99) < 75);
      cycle();
    end
    vprob = 100; mrdy_nx = 1'b1;
    drain(n);
    for (int p = 0; p < NP; p++) chk("sb_left", 64'(sbq[p].size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/arbiter_stream_mux.md
ARBITER_STREAM_MUX -- requirements
Module: arbiter_stream_mux

Interface
REQ-001 Parameter NUM_PORTS, default 4, number of input streams (legal 2..16).
REQ-002 Parameter DATA_WIDTH, default 32, beat width in bits.
REQ-003 Parameter MAX_BURST, default 16, maximum beats per grant before forced re-arbitration (legal 1..255).
REQ-004 Derived SEL_WIDTH = clog2(NUM_PORTS), minimum 1.
REQ-005 clk  input  1  single clock; all state changes on rising edge.
REQ-006 rst  input  1  reset, synchronous, active-low.
REQ-007 s_data  input  NUM_PORTS*DATA_WIDTH  per-port beat data; port i at bits [i*DATA_WIDTH +: DATA_WIDTH].
REQ-008 s_valid  input  NUM_PORTS  per-port beat valid.
REQ-009 s_last  input  NUM_PORTS  per-port end-of-packet marker, qualified by s_valid.
REQ-010 s_ready  output  NUM_PORTS  per-port beat accept.
REQ-011 m_data  output  DATA_WIDTH  muxed beat data.
REQ-012 m_valid  output  1  muxed beat valid.
REQ-013 m_last  output  1  muxed end-of-packet.
REQ-014 m_ready  input  1  downstream accept.
REQ-015 m_select  output  SEL_WIDTH  index of the currently granted port.
REQ-016 active  output  1  high while a port holds the grant.

Function
REQ-017 Transfer on a port occurs in a cycle where its valid and ready are both high.
REQ-018 FSM states: IDLE, LOCK.
REQ-019 IDLE: if any s_valid is high, pick a winner by round-robin, register m_select, go to LOCK next cycle; otherwise stay.
REQ-020 Arbitration latency: exactly one IDLE cycle between a request appearing and the grant taking effect; no beat transfers in IDLE.
REQ-021 In IDLE, all s_ready, m_valid, m_last are 0.
REQ-022 LOCK: m_valid = s_valid[m_select], m_data = s_data[m_select], m_last = s_last[m_select], s_ready[m_select] = m_ready, all other s_ready = 0 (combinational pass-through, zero added data latency).
REQ-023 Beat counter increments on every LOCK transfer; cleared on entry to LOCK.
REQ-024 LOCK -> IDLE on a transfer with m_last high, or on the transfer that brings the beat counter to MAX_BURST (forced release mid-packet).
REQ-025 Granted port dropping s_valid in LOCK does not release the grant; no timeout.
REQ-026 Round-robin: after release, the just-served port becomes lowest priority; search order starts at m_select+1, wrapping from NUM_PORTS-1 to 0.
REQ-027 A sole requester is re-granted after one IDLE bubble cycle.
REQ-028 Requests changing on the release cycle are evaluated in the following IDLE cycle only.
REQ-029 active = 1 exactly when state is LOCK.
REQ-030 A port that was force-released mid-packet re-arbitrates normally; packet continuation is the requester's responsibility.

Reset
REQ-031 While rst is low at a rising edge: state IDLE, beat counter 0, m_select 0, priority pointer such that port 0 is highest priority.
REQ-032 Outputs during and after reset until first grant: s_ready 0, m_valid 0, m_last 0, active 0, m_select 0; m_data don't-care.
REQ-033 Reset asserted mid-packet aborts the grant immediately; no beat is accepted in the reset cycle.

Structure
REQ-034 Shared package/header holds the SEL_WIDTH function and IDLE/LOCK state encodings.
REQ-035 One sub-module, rr_pick: combinational round-robin picker (request vector, priority pointer -> one-hot winner and index).
REQ-036 Data mux, FSM, counter and pointer live in arbiter_stream_mux.

Verification
REQ-037 Reset: rst low 10 cycles with all s_valid=1 -> s_ready=0000, m_valid=0, active=0, m_select=0 throughout.
REQ-038 All four ports stream 3-beat packets, m_ready=1 -> grants in order 0,1,2,3,0; each packet 3 beats contiguous; one idle cycle between packets.
REQ-039 Port 2 alone sends 40-beat packet, MAX_BURST=16 -> forced release after beats 16 and 32; re-granted after one bubble; 40 beats delivered in order.
REQ-040 Port 1 granted, m_ready=0 for 5 cycles mid-packet -> m_data/m_valid held stable, s_ready[1]=0, no beat lost or duplicated.
REQ-041 Port 3 granted, s_valid[3] drops 4 cycles while port 0 requests -> grant stays on port 3 (m_select=3, active=1) until its last beat.
REQ-042 rst low for one cycle mid-packet on port 1 -> next cycle IDLE, active=0; subsequent request on ports 1 and 0 grants port 0 first.
